// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed four-digit seven-segment display driver.
// Loads {VALUE, DIGIT_EN} through a one-entry pending buffer (valid/ready) and
// applies it to the display register only at frame boundaries.
// Optional feature macro: SEG_SCAN_DP_EN adds DP_IN[3:0] decimal-point inputs.
module seg_scan_driver #(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] VALUE,
    input  logic [3:0]  DIGIT_EN,
`ifdef SEG_SCAN_DP_EN
    input  logic [3:0]  DP_IN,
`endif
    input  logic        LOAD_VALID,
    output logic        LOAD_READY,
    output logic [6:0]  SEGMENTS,
    output logic        DP,
    output logic [3:0]  AN,
    output logic        FRAME_TICK
);

    localparam int unsigned     PS_W     = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0] PS_BLANK = PS_W'(BLANK_CYC);
    localparam logic [PS_W-1:0] PS_ONE   = PS_W'(1);

    logic            r_run;
    logic [PS_W-1:0] r_prescale;
    logic [1:0]      r_idx;
    logic [15:0]     r_pend_val;
    logic [3:0]      r_pend_en;
    logic            r_pend_full;
    logic [15:0]     r_disp_val;
    logic [3:0]      r_disp_en;
    logic [3:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_frame_tick;

    logic            w_wrap;
    logic            w_boundary;
    logic            w_load;
    logic            w_take;
    logic            w_lit;
    logic [3:0]      w_nibble;

    // Hex nibble to active-low segments, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] f_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign w_wrap     = (r_prescale == PS_LAST);
    assign w_boundary = r_run & w_wrap & (r_idx == 2'd3);
    assign w_load     = LOAD_VALID & ~r_pend_full;
    assign w_take     = w_boundary & r_pend_full;
    assign w_nibble   = r_disp_val[{r_idx, 2'b00} +: 4];
    assign w_lit      = (r_prescale >= PS_BLANK) & r_disp_en[r_idx];

    // Reset release synchroniser: one stage, so counting starts on the second edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_run <= 1'b0;
        else          r_run <= 1'b1;
    end

    // Slot prescaler and digit index; idx 3 -> 0 wrap is the frame boundary.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_prescale <= '0;
            r_idx      <= '0;
        end else if (r_run) begin
            if (w_wrap) begin
                r_prescale <= '0;
                r_idx      <= r_idx + 2'd1;
            end else begin
                r_prescale <= r_prescale + PS_ONE;
            end
        end
    end

    // Pending buffer handshake and frame-boundary transfer into the display register.
    // Handshake is not gated by r_run: upstream shares this reset domain, and
    // LOAD_READY must already be high while reset is held.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pend_val  <= '0;
            r_pend_en   <= '0;
            r_pend_full <= 1'b0;
            r_disp_val  <= '0;
            r_disp_en   <= '0;
        end else begin
            // w_take and w_load are exclusive: a load needs the buffer empty.
            if (w_take) begin
                r_disp_val  <= r_pend_val;
                r_disp_en   <= r_pend_en;
                r_pend_full <= 1'b0;
            end
            if (w_load) begin
                r_pend_val  <= VALUE;
                r_pend_en   <= DIGIT_EN;
                r_pend_full <= 1'b1;
            end
        end
    end

    // Registered scan outputs, one cycle behind prescale/idx.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_an         <= '1;
            r_seg        <= '1;
            r_frame_tick <= 1'b0;
        end else if (r_run) begin
            r_an         <= w_lit ? ~(4'b0001 << r_idx) : 4'b1111;
            r_seg        <= w_lit ? f_encode(w_nibble) : 7'h7F;
            r_frame_tick <= w_boundary;
        end
    end

`ifdef SEG_SCAN_DP_EN
    logic [3:0] r_pend_dp;
    logic [3:0] r_disp_dp;
    logic       r_dp;

    // Decimal points travel with VALUE through pending and display.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pend_dp <= '0;
            r_disp_dp <= '0;
            r_dp      <= 1'b1;
        end else begin
            if (w_take) r_disp_dp <= r_pend_dp;
            if (w_load) r_pend_dp <= DP_IN;
            if (r_run)  r_dp      <= w_lit ? ~r_disp_dp[r_idx] : 1'b1;
        end
    end

    assign DP = r_dp;
`else
    assign DP = 1'b1;
`endif

    assign LOAD_READY = ~r_pend_full;
    assign AN         = r_an;
    assign SEGMENTS   = r_seg;
    assign FRAME_TICK = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed testbench for seg_scan_driver (TICK_DIV=8, BLANK_CYC=2).
module tb_seg_scan_driver;

    localparam int unsigned TICK_DIV  = 8;
    localparam int unsigned BLANK_CYC = 2;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic        load_valid;
    logic        load_ready;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;
`ifdef SEG_SCAN_DP_EN
    logic [3:0]  dp_in;
`endif

    int tests  = 0;
    int failed = 0;

    // One frame of samples, index 8*slot + cycle-within-slot.
    logic [3:0] an_s  [32];
    logic [6:0] seg_s [32];
    logic       dp_s  [32];
    logic       ft_s  [32];
    logic       rdy_s [32];

    seg_scan_driver #(
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .VALUE      (value),
        .DIGIT_EN   (digit_en),
`ifdef SEG_SCAN_DP_EN
        .DP_IN      (dp_in),
`endif
        .LOAD_VALID (load_valid),
        .LOAD_READY (load_ready),
        .SEGMENTS   (segments),
        .DP         (dp),
        .AN         (an),
        .FRAME_TICK (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic sample_frame();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            an_s[i]  = an;
            seg_s[i] = segments;
            dp_s[i]  = dp;
            ft_s[i]  = frame_tick;
            rdy_s[i] = load_ready;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] e, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (load_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            value      = v;
            digit_en   = e;
            load_valid = 1'b1;
            @(negedge clk);
            load_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        bit ok;
        int gap;
        int lit_bad;
        // Power-on reset values
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (an !== 4'b1111 || segments !== 7'h7F || dp !== 1'b1 ||
            frame_tick !== 1'b0 || load_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_por: AN=%b SEG=%h DP=%b FT=%b RDY=%b, want 1111 7f 1 0 1",
                     an, segments, dp, frame_tick, load_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        gap = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                gap = i;
                break;
            end
        end
        tests++;
        if (gap != 33) begin
            failed++;
            $display("FAIL reset_first_tick: got %0d cycles, want 33", gap);
        end

        // Mid-slot reset with a digit lit and the pending buffer full
        do_load(16'h1234, 4'b1111, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL reset_load1: accepted=%0d, want 1", ok); end
        wait_tick(ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL reset_tick: seen=%0d, want 1", ok); end
        do_load(16'h5555, 4'b1111, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL reset_load2: accepted=%0d, want 1", ok); end
        repeat (3) @(negedge clk);
        tests++;
        if (an !== 4'b1110 || segments !== 7'h19 || load_ready !== 1'b0) begin
            failed++;
            $display("FAIL reset_pre_lit: AN=%b SEG=%h RDY=%b, want 1110 19 0",
                     an, segments, load_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (an !== 4'b1111 || segments !== 7'h7F || dp !== 1'b1 ||
            frame_tick !== 1'b0 || load_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_midslot: AN=%b SEG=%h DP=%b FT=%b RDY=%b, want 1111 7f 1 0 1",
                     an, segments, dp, frame_tick, load_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        gap = 0;
        lit_bad = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (an !== 4'b1111) lit_bad++;
            if (frame_tick === 1'b1) begin
                gap = i;
                break;
            end
        end
        tests++;
        if (gap != 33) begin
            failed++;
            $display("FAIL reset_restart_idx0: got %0d cycles to tick, want 33", gap);
        end
        tests++;
        if (lit_bad != 0) begin
            failed++;
            $display("FAIL reset_display_cleared: got %0d lit cycles, want 0", lit_bad);
        end
    endtask

    task automatic test_decode();
        logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] exp_seg [4] = '{7'h10, 7'h24, 7'h40, 7'h24};
        bit ok;
        do_load(16'h2029, 4'b1111, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL decode_load: accepted=%0d, want 1", ok); end
        wait_tick(ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL decode_tick: seen=%0d, want 1", ok); end
        sample_frame();
        for (int k = 0; k < 4; k++) begin
            for (int j = 2; j < 8; j++) begin
                tests++;
                if (an_s[8*k+j] !== exp_an[k] || seg_s[8*k+j] !== exp_seg[k] ||
                    dp_s[8*k+j] !== 1'b1) begin
                    failed++;
                    $display("FAIL decode_slot%0d_c%0d: AN=%b SEG=%h DP=%b, want %b %h 1",
                             k, j, an_s[8*k+j], seg_s[8*k+j], dp_s[8*k+j], exp_an[k], exp_seg[k]);
                end
            end
        end
    endtask

    task automatic test_blanking();
        bit ok;
        int lit;
        wait_tick(ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL blank_tick: seen=%0d, want 1", ok); end
        sample_frame();
        for (int k = 0; k < 4; k++) begin
            lit = 0;
            for (int j = 0; j < 8; j++) begin
                if (an_s[8*k+j] !== 4'b1111) lit++;
                tests++;
                if (!$onehot0(~an_s[8*k+j])) begin
                    failed++;
                    $display("FAIL blank_onehot_s%0d_c%0d: AN=%b, want at most one low",
                             k, j, an_s[8*k+j]);
                end
            end
            for (int j = 0; j < 2; j++) begin
                tests++;
                if (an_s[8*k+j] !== 4'b1111 || seg_s[8*k+j] !== 7'h7F) begin
                    failed++;
                    $display("FAIL blank_slot%0d_c%0d: AN=%b SEG=%h, want 1111 7f",
                             k, j, an_s[8*k+j], seg_s[8*k+j]);
                end
            end
            tests++;
            if (lit != 6) begin
                failed++;
                $display("FAIL blank_lit_count_s%0d: got %0d, want 6", k, lit);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        bit ok;
        bit seen;
        int held_bad;
        do_load(16'h1111, 4'b1111, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL b2b_load1: accepted=%0d, want 1", ok); end
        tests++;
        if (load_ready !== 1'b0) begin
            failed++;
            $display("FAIL b2b_ready_drop: RDY=%b, want 0", load_ready);
        end
        value      = 16'h2222;
        digit_en   = 4'b1111;
        load_valid = 1'b1;
        seen       = 1'b0;
        held_bad   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (load_ready !== 1'b0) held_bad++;
        end
        tests++;
        if (!seen) begin failed++; $display("FAIL b2b_tick: seen=%0d, want 1", seen); end
        tests++;
        if (held_bad != 0) begin
            failed++;
            $display("FAIL b2b_held: RDY high %0d cycles while full, want 0", held_bad);
        end
        tests++;
        if (load_ready !== 1'b1) begin
            failed++;
            $display("FAIL b2b_ready_after_boundary: RDY=%b, want 1", load_ready);
        end
        sample_frame();
        load_valid = 1'b0;
        tests++;
        if (rdy_s[0] !== 1'b0 || rdy_s[31] !== 1'b1 || ft_s[31] !== 1'b1) begin
            failed++;
            $display("FAIL b2b_accept2: RDY[0]=%b RDY[31]=%b FT[31]=%b, want 0 1 1",
                     rdy_s[0], rdy_s[31], ft_s[31]);
        end
        for (int k = 0; k < 4; k++) begin
            for (int j = 2; j < 8; j++) begin
                tests++;
                if (an_s[8*k+j] !== exp_an[k] || seg_s[8*k+j] !== 7'h79) begin
                    failed++;
                    $display("FAIL b2b_show1111_s%0d_c%0d: AN=%b SEG=%h, want %b 79",
                             k, j, an_s[8*k+j], seg_s[8*k+j], exp_an[k]);
                end
            end
        end
        sample_frame();
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (an_s[8*k+5] !== exp_an[k] || seg_s[8*k+5] !== 7'h24) begin
                failed++;
                $display("FAIL b2b_show2222_s%0d: AN=%b SEG=%h, want %b 24",
                         k, an_s[8*k+5], seg_s[8*k+5], exp_an[k]);
            end
        end
    endtask

    task automatic test_digit_enable();
        bit ok;
        do_load(16'hABCD, 4'b0011, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL den_load: accepted=%0d, want 1", ok); end
        wait_tick(ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL den_tick: seen=%0d, want 1", ok); end
        sample_frame();
        for (int j = 2; j < 8; j++) begin
            tests++;
            if (an_s[j] !== 4'b1110 || seg_s[j] !== 7'h21) begin
                failed++;
                $display("FAIL den_slot0_c%0d: AN=%b SEG=%h, want 1110 21", j, an_s[j], seg_s[j]);
            end
            tests++;
            if (an_s[8+j] !== 4'b1101 || seg_s[8+j] !== 7'h46) begin
                failed++;
                $display("FAIL den_slot1_c%0d: AN=%b SEG=%h, want 1101 46", j, an_s[8+j], seg_s[8+j]);
            end
        end
        for (int i = 16; i < 32; i++) begin
            tests++;
            if (an_s[i] !== 4'b1111 || seg_s[i] !== 7'h7F) begin
                failed++;
                $display("FAIL den_off_i%0d: AN=%b SEG=%h, want 1111 7f", i, an_s[i], seg_s[i]);
            end
        end
    endtask

    task automatic test_frame_spacing();
        logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] exp_seg [4] = '{7'h00, 7'h78, 7'h02, 7'h12};
        bit ok;
        int gap;
        int ft_bad;
        wait_tick(ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL spacing_tick: seen=%0d, want 1", ok); end
        gap = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                gap = i;
                break;
            end
        end
        tests++;
        if (gap != 32) begin
            failed++;
            $display("FAIL spacing_gap: got %0d cycles, want 32", gap);
        end
        // Present a load so it is accepted on the boundary edge itself
        repeat (31) @(negedge clk);
        tests++;
        if (load_ready !== 1'b1 || frame_tick !== 1'b0) begin
            failed++;
            $display("FAIL spacing_pre: RDY=%b FT=%b, want 1 0", load_ready, frame_tick);
        end
        value      = 16'h5678;
        digit_en   = 4'b1111;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        tests++;
        if (frame_tick !== 1'b1 || load_ready !== 1'b0) begin
            failed++;
            $display("FAIL spacing_coincident: FT=%b RDY=%b, want 1 0", frame_tick, load_ready);
        end
        sample_frame();
        ft_bad = 0;
        for (int i = 0; i < 31; i++) if (ft_s[i] !== 1'b0) ft_bad++;
        tests++;
        if (ft_bad != 0 || ft_s[31] !== 1'b1) begin
            failed++;
            $display("FAIL spacing_pulse: extra=%0d FT[31]=%b, want 0 1", ft_bad, ft_s[31]);
        end
        tests++;
        if (an_s[4] !== 4'b1110 || seg_s[4] !== 7'h21 || an_s[20] !== 4'b1111) begin
            failed++;
            $display("FAIL spacing_old_value: AN0=%b SEG0=%h AN2=%b, want 1110 21 1111",
                     an_s[4], seg_s[4], an_s[20]);
        end
        sample_frame();
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (an_s[8*k+6] !== exp_an[k] || seg_s[8*k+6] !== exp_seg[k]) begin
                failed++;
                $display("FAIL spacing_new_s%0d: AN=%b SEG=%h, want %b %h",
                         k, an_s[8*k+6], seg_s[8*k+6], exp_an[k], exp_seg[k]);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        value      = '0;
        digit_en   = '0;
        load_valid = 1'b0;
`ifdef SEG_SCAN_DP_EN
        dp_in      = '0;
`endif
        test_reset();
        test_decode();
        test_blanking();
        test_back_to_back();
        test_digit_enable();
        test_frame_spacing();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
